// File: rtl/cmat_pkg.sv
// Shared types and constants for the complex triangular-matrix datapath.
package cmat_pkg;

    localparam int unsigned DW_DEFAULT = 64;

    localparam logic [63:0] FP64_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] FP64_ONE  = 64'h3FF0_0000_0000_0000;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] im;
        logic [DW_DEFAULT-1:0] re;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_e;

endpackage

// File: rtl/tri_matrix_row_server_if.sv
// Load-stream and row-fetch handshake bundle of tri_matrix_row_server.
interface tri_matrix_row_server_if #(
    parameter int unsigned SIZE = 16,
    parameter int unsigned DW   = 64
);
    localparam int unsigned AW = $clog2(SIZE);

    logic                          flush_i;
    logic                          start_i;
    logic [2*DW-1:0]               elem_i;
    logic                          elem_valid_i;
    logic                          elem_ready_o;
    logic                          load_done_o;
    logic [AW-1:0]                 rd_addr_i;
    logic                          rd_addr_valid_i;
    logic [SIZE-1:0][2*DW-1:0]     mat_row_o;
    logic [AW-1:0]                 mat_row_addr_o;
    logic                          mat_row_valid_o;
    logic                          release_i;
    logic                          busy_o;
    logic                          diag_zero_o;

    modport slave (
        input  flush_i, start_i, elem_i, elem_valid_i, rd_addr_i, rd_addr_valid_i, release_i,
        output elem_ready_o, load_done_o, mat_row_o, mat_row_addr_o, mat_row_valid_o, busy_o,
               diag_zero_o
    );

    modport master (
        output flush_i, start_i, elem_i, elem_valid_i, rd_addr_i, rd_addr_valid_i, release_i,
        input  elem_ready_o, load_done_o, mat_row_o, mat_row_addr_o, mat_row_valid_o, busy_o,
               diag_zero_o
    );

endinterface

// File: rtl/tri_load_counter.sv
// Row/column walk over the lower triangle in row-major order; flags the final element.
module tri_load_counter #(
    parameter int unsigned SIZE = 16,
    localparam int unsigned AW  = $clog2(SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [AW-1:0] row_o,
    output logic [AW-1:0] col_o,
    output logic          last_o
);

    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            // Row r holds r+1 elements, so the diagonal closes the row.
            if (col_q == row_q) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == AW'(SIZE - 1)) && (col_q == AW'(SIZE - 1));

endmodule

// File: rtl/tri_matrix_row_server.sv
// Loads a lower-triangular complex matrix from a stream and serves whole rows on request.
// Optional zero-diagonal detection is enabled by TRI_MATRIX_ROW_SERVER_DIAG_CHECK_EN.
module tri_matrix_row_server
    import cmat_pkg::*;
#(
    parameter int unsigned SIZE = 16,
    parameter int unsigned DW   = 64
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    tri_matrix_row_server_if.slave  bus
);

    localparam int unsigned AW = $clog2(SIZE);

    state_e                            state_q, state_d;
    logic                              start_ok, accept, clr_cnt, last, rd_fire;
    logic                              load_done_q, row_valid_q;
    logic [AW-1:0]                     row, col, row_addr_q;
    logic [SIZE-1:0][SIZE-1:0][2*DW-1:0] mem_q;
    logic [SIZE-1:0][2*DW-1:0]         row_sel, row_q;

    // Flush overrides every other event in the same cycle.
    assign start_ok = (state_q == IDLE) && bus.start_i && !bus.flush_i;
    assign accept   = (state_q == LOAD) && bus.elem_valid_i && !bus.flush_i;
    assign clr_cnt  = bus.flush_i || start_ok;
    assign rd_fire  = (state_q == SERVE) && bus.rd_addr_valid_i && !bus.release_i && !bus.flush_i;

    tri_load_counter #(
        .SIZE (SIZE)
    ) u_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clr_cnt),
        .advance_i (accept),
        .row_o     (row),
        .col_o     (col),
        .last_o    (last)
    );

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (bus.start_i)   state_d = LOAD;
                LOAD:    if (accept && last) state_d = SERVE;
                SERVE:   if (bus.release_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_done_q <= accept && last;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (start_ok) begin
            mem_q <= '0;
        end else if (accept) begin
            mem_q[row][col] <= bus.elem_i;
        end
    end

    // Mask the upper triangle so it reads as zero even if stale data were ever present.
    always_comb begin
        row_sel = '0;
        for (int j = 0; j < int'(SIZE); j++) begin
            if (AW'(j) <= bus.rd_addr_i) row_sel[j] = mem_q[bus.rd_addr_i][j];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_valid_q <= 1'b0;
            row_addr_q  <= '0;
            row_q       <= '0;
        end else begin
            row_valid_q <= rd_fire;
            if (rd_fire) begin
                row_addr_q <= bus.rd_addr_i;
                row_q      <= row_sel;
            end
        end
    end

`ifdef TRI_MATRIX_ROW_SERVER_DIAG_CHECK_EN
    logic diag_zero_q, diag_hit;

    // Sign bits ignored: both +0 and -0 count as zero.
    assign diag_hit = accept && (col == row) && (bus.elem_i[DW-2:0] == '0)
                      && (bus.elem_i[2*DW-2:DW] == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            diag_zero_q <= 1'b0;
        end else if (clr_cnt) begin
            diag_zero_q <= 1'b0;
        end else if (diag_hit) begin
            diag_zero_q <= 1'b1;
        end
    end

    assign bus.diag_zero_o = diag_zero_q;
`else
    assign bus.diag_zero_o = 1'b0;
`endif

    assign bus.elem_ready_o    = (state_q == LOAD);
    assign bus.load_done_o     = load_done_q;
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.mat_row_valid_o = row_valid_q;
    assign bus.mat_row_addr_o  = row_addr_q;
    assign bus.mat_row_o       = row_q;

endmodule

// File: tb/tb_tri_matrix_row_server.sv
// Self-checking bench for tri_matrix_row_server: table vectors plus a row scoreboard.
module tb_tri_matrix_row_server;
    import cmat_pkg::*;

    localparam int SIZE = 16;
    localparam int EW   = 128;
`ifdef TRI_MATRIX_ROW_SERVER_DIAG_CHECK_EN
    localparam int DIAG_EN = 1;
`else
    localparam int DIAG_EN = 0;
`endif

    typedef logic [SIZE-1:0][EW-1:0] row_t;
    typedef struct {
        logic [3:0] addr;
        row_t       row;
    } sb_t;
    typedef struct {
        bit         req;
        logic [3:0] addr;
        bit         rel;
        bit         exp_valid;
        logic [3:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    row_t mdl [SIZE];
    sb_t  sb [$];
    sb_t  mon_e;
    vec_t vecs [8];

    tri_matrix_row_server_if #(.SIZE(SIZE), .DW(64)) bus ();

    tri_matrix_row_server #(.SIZE(SIZE), .DW(64)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] elem_val(input int kind, input int r, input int c);
        cplx_t e;
        int    v = r * 16 + c;
        case (kind)
            0: begin e.re = 64'(v); e.im = -64'(v); end
            1: begin e.re = 64'(1000 + v); e.im = 64'(r + 1); end
            default: begin
                e.re = (r == 3 && c == 3) ? 64'h8000_0000_0000_0000 : 64'(v + 1);
                e.im = FP64_ZERO;
            end
        endcase
        return e;
    endfunction

    function automatic row_t exp_row(input int a);
        row_t x = '0;
        for (int j = 0; j <= a; j++) x[j] = mdl[a][j];
        return x;
    endfunction

    task automatic req_row(input int a);
        sb_t e;
        bus.rd_addr_valid_i = 1'b1;
        bus.rd_addr_i = 4'(a);
        e.addr = 4'(a);
        e.row = exp_row(a);
        sb.push_back(e);
        tick();
        bus.rd_addr_valid_i = 1'b0;
        chk("req_valid", int'(bus.mat_row_valid_o), 1);
    endtask

    task automatic do_release();
        bus.release_i = 1'b1;
        tick();
        bus.release_i = 1'b0;
        chk("release_idle", int'(bus.busy_o), 0);
    endtask

    // stop_after > 0 flushes the load after that many accepts.
    task automatic load_matrix(input int kind, input bit rnd, input int stop_after);
        int acc = 0;
        int pulses = 0;
        int guard;
        bit rdy;
        bit v;
        for (int i = 0; i < SIZE; i++) mdl[i] = '0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("start_busy", int'(bus.busy_o), 1);
        chk("start_diag_clr", int'(bus.diag_zero_o), 0);
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c <= r; c++) begin
                guard = 0;
                do begin
                    v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus.elem_valid_i = v;
                    bus.elem_i = elem_val(kind, r, c);
                    bus.rd_addr_valid_i = rnd;
                    bus.rd_addr_i = 4'd2;
                    rdy = bus.elem_ready_o;
                    tick();
                    guard++;
                    if (bus.load_done_o) pulses++;
                end while (!(v && rdy) && guard < 64);
                if (!(v && rdy)) begin
                    chk("accept_timeout", 0, 1);
                    bus.elem_valid_i = 1'b0;
                    bus.rd_addr_valid_i = 1'b0;
                    return;
                end
                acc++;
                mdl[r][c] = elem_val(kind, r, c);
                if (kind == 2 && r == 3 && c == 3)
                    chk("diag_after_33", int'(bus.diag_zero_o), DIAG_EN);
                if (rnd && acc == 70) chk("no_row_in_load", int'(bus.mat_row_valid_o), 0);
                if (acc == stop_after) begin
                    bus.elem_valid_i = 1'b0;
                    bus.rd_addr_valid_i = 1'b0;
                    bus.flush_i = 1'b1;
                    tick();
                    bus.flush_i = 1'b0;
                    chk("flush_idle", int'(bus.busy_o), 0);
                    chk("flush_no_done", pulses, 0);
                    return;
                end
            end
        end
        chk("accept_count", acc, SIZE * (SIZE + 1) / 2);
        chk("load_done_first", int'(bus.load_done_o), 1);
        bus.elem_valid_i = 1'b0;
        bus.rd_addr_valid_i = 1'b0;
        tick();
        if (bus.load_done_o) pulses++;
        chk("load_done_pulses", pulses, 1);
        chk("ready_in_serve", int'(bus.elem_ready_o), 0);
        chk("serve_busy", int'(bus.busy_o), 1);
    endtask

    initial begin
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        bus.elem_i = '0;
        bus.elem_valid_i = 1'b0;
        bus.rd_addr_i = '0;
        bus.rd_addr_valid_i = 1'b0;
        bus.release_i = 1'b0;

        vecs[0] = '{1'b1, 4'd7,  1'b0, 1'b1, 4'd7};
        vecs[1] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd7};
        vecs[2] = '{1'b1, 4'd0,  1'b0, 1'b1, 4'd0};
        vecs[3] = '{1'b1, 4'd15, 1'b0, 1'b1, 4'd15};
        vecs[4] = '{1'b0, 4'd3,  1'b0, 1'b0, 4'd15};
        vecs[5] = '{1'b1, 4'd9,  1'b0, 1'b1, 4'd9};
        vecs[6] = '{1'b1, 4'd4,  1'b1, 1'b0, 4'd9};
        vecs[7] = '{1'b1, 4'd2,  1'b0, 1'b0, 4'd9};

        fork
            forever begin
                @(negedge clk);
                if (rst_n && bus.mat_row_valid_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_row", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("row_addr", int'(bus.mat_row_addr_o), int'(mon_e.addr));
                        n_checks++;
                        if (bus.mat_row_o !== mon_e.row) begin
                            int bad = -1;
                            n_fail++;
                            for (int j = SIZE - 1; j >= 0; j--)
                                if (bus.mat_row_o[j] !== mon_e.row[j]) bad = j;
                            if (bad >= 0)
                                $display("FAIL row_data row %0d elem %0d: got %h expected %h",
                                         mon_e.addr, bad, bus.mat_row_o[bad], mon_e.row[bad]);
                            else
                                $display("FAIL row_data row %0d: got unknown bits", mon_e.addr);
                        end
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) tick();
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_ready", int'(bus.elem_ready_o), 0);
        chk("rst_load_done", int'(bus.load_done_o), 0);
        chk("rst_row_valid", int'(bus.mat_row_valid_o), 0);
        chk("rst_row_addr", int'(bus.mat_row_addr_o), 0);
        chk("rst_row_zero", int'(bus.mat_row_o == '0), 1);
        chk("rst_diag", int'(bus.diag_zero_o), 0);
        rst_n = 1'b1;
        tick();

        // Test 1: full load, then row 5
        load_matrix(0, 1'b0, 0);
        chk("diag_kind0", int'(bus.diag_zero_o), DIAG_EN);
        req_row(5);

        // Test 2: back-to-back rows 0..15
        for (int a = 0; a < SIZE; a++) req_row(a);
        tick();
        chk("b2b_drained", sb.size(), 0);

        // Table vectors: gaps hold addr, release-coincident and idle requests dropped
        for (int i = 0; i < 8; i++) begin
            bus.rd_addr_valid_i = vecs[i].req;
            bus.rd_addr_i = vecs[i].addr;
            bus.release_i = vecs[i].rel;
            if (vecs[i].exp_valid) begin
                mon_e.addr = vecs[i].addr;
                mon_e.row = exp_row(int'(vecs[i].addr));
                sb.push_back(mon_e);
            end
            tick();
            bus.rd_addr_valid_i = 1'b0;
            bus.release_i = 1'b0;
            chk("vec_valid", int'(bus.mat_row_valid_o), int'(vecs[i].exp_valid));
            chk("vec_addr", int'(bus.mat_row_addr_o), int'(vecs[i].exp_addr));
        end
        chk("vec_idle", int'(bus.busy_o), 0);

        // Test 3: randomly gapped valid, requests held during load
        load_matrix(0, 1'b1, 0);
        for (int a = 0; a < SIZE; a++) req_row(a);
        do_release();

        // Test 4: flush mid-load, then reload with new data
        load_matrix(1, 1'b0, 40);
        bus.rd_addr_valid_i = 1'b1;
        bus.rd_addr_i = 4'd1;
        tick();
        bus.rd_addr_valid_i = 1'b0;
        tick();
        chk("idle_req_dropped", int'(bus.mat_row_valid_o), 0);
        load_matrix(1, 1'b0, 0);
        chk("diag_kind1", int'(bus.diag_zero_o), 0);
        for (int a = SIZE - 1; a >= 0; a--) req_row(a);
        do_release();

        // Test 5: signed-zero diagonal at (3,3)
        load_matrix(2, 1'b0, 0);
        req_row(3);
        do_release();
        chk("diag_held_idle", int'(bus.diag_zero_o), DIAG_EN);
        load_matrix(1, 1'b0, 0);

        // Test 6: async reset during SERVE with request pending
        bus.rd_addr_valid_i = 1'b1;
        bus.rd_addr_i = 4'd6;
        mon_e.addr = 4'd6;
        mon_e.row = exp_row(6);
        sb.push_back(mon_e);
        tick();
        chk("pre_rst_valid", int'(bus.mat_row_valid_o), 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(bus.mat_row_valid_o), 0);
        chk("arst_busy", int'(bus.busy_o), 0);
        chk("arst_addr", int'(bus.mat_row_addr_o), 0);
        chk("arst_row_zero", int'(bus.mat_row_o == '0), 1);
        bus.rd_addr_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", int'(bus.busy_o), 0);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
